// File: rtl/fusion_pkg.sv
// Shared types and encoding helpers for the fusion-unit operand formatter.
package fusion_pkg;

    // One-hot bitwidth codes understood by the fusion unit.
    typedef enum logic [2:0] {
        BW_2B = 3'b001,
        BW_4B = 3'b010,
        BW_8B = 3'b100
    } bw_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fmt_state_e;

    // FIFO entry: {last, input_forward, weight}
    localparam int unsigned EntryW = 65;

    function automatic logic bw_legal(logic [2:0] code);
        logic ok;
        case (code)
            BW_2B, BW_4B, BW_8B: ok = 1'b1;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [7:0] bw_mask(bw_t bw);
        logic [7:0] m;
        case (bw)
            BW_2B:   m = 8'h03;
            BW_4B:   m = 8'h0f;
            BW_8B:   m = 8'hff;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    // Each 2-bit brick of the activation is replicated across its own output byte.
    function automatic logic [31:0] encode_act(bw_t bw, logic [7:0] act);
        logic [7:0]  m;
        logic [31:0] r;
        m = act & bw_mask(bw);
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = {4{m[2*k +: 2]}};
        end
        return r;
    endfunction

    function automatic logic [31:0] encode_wgt(bw_t bw, logic [7:0] wgt);
        return {4{wgt & bw_mask(bw)}};
    endfunction

endpackage

// File: rtl/fusion_fmt_fifo.sv
// Registered (no fall-through) FIFO holding encoded operand words.
module fusion_fmt_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 65,
    parameter int unsigned LvlW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LvlW-1:0]  level
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == LvlW'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer wrap, occupancy and storage update.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + LvlW'(1);
            2'b01:   count_d = count_q - LvlW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; storage cleared so outputs read zero out of reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fusion_operand_formatter.sv
// Producer side of the fusion-unit operand interface: encodes raw activation/weight
// byte pairs into bit-brick words and buffers them for the fusion-unit row.
// Optional build macro FUSION_FMT_STATS_EN adds a saturating stall_cnt output.
module fusion_operand_formatter
    import fusion_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             cfg_start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [2:0]       cfg_in_bw,
    input  logic [2:0]       cfg_wt_bw,
    input  logic             cfg_in_signed,
    input  logic             cfg_wt_signed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_act,
    input  logic [7:0]       in_wgt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      input_forward,
    output logic [31:0]      weight,
    output logic [2:0]       input_bitwidth,
    output logic [2:0]       weight_bitwidth,
    output logic [3:0]       input_sign,
    output logic [3:0]       weight_sign,
    output logic             out_last,
    output logic             busy,
`ifdef FUSION_FMT_STATS_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic             done,
    output logic             err
);

    localparam int unsigned LvlW = $clog2(DEPTH + 1);

    fmt_state_e       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [2:0]       in_bw_q, in_bw_d;
    logic [2:0]       wt_bw_q, wt_bw_d;
    logic             in_signed_q, in_signed_d;
    logic             wt_signed_q, wt_signed_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic              cfg_legal;
    logic              start_accept;
    logic              push, pop;
    logic              fifo_full, fifo_empty;
    logic [LvlW-1:0]   fifo_level;
    logic [EntryW-1:0] fifo_wdata, fifo_rdata;
    logic              beat_last;

    assign cfg_legal    = bw_legal(cfg_in_bw) && bw_legal(cfg_wt_bw);
    assign start_accept = (state_q == IDLE) && cfg_start && cfg_legal;

    assign in_ready  = (state_q == RUN) && !fifo_full;
    assign push      = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign beat_last = (cnt_q == LEN_W'(1));

    assign fifo_wdata = {beat_last,
                         encode_act(bw_t'(in_bw_q), in_act),
                         encode_wgt(bw_t'(wt_bw_q), in_wgt)};

    fusion_fmt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW),
        .LvlW  (LvlW)
    ) u_fifo (
        .clk   (clk),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign {out_last, input_forward, weight} = fifo_rdata;
    assign input_bitwidth  = in_bw_q;
    assign weight_bitwidth = wt_bw_q;
    assign input_sign      = {4{in_signed_q}};
    assign weight_sign     = {4{wt_signed_q}};
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign err             = err_q;

    // Vector sequencing: config check, beat countdown, drain-then-done.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_bw_d     = in_bw_q;
        wt_bw_d     = wt_bw_q;
        in_signed_d = in_signed_q;
        wt_signed_d = wt_signed_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (!cfg_legal) begin
                        err_d = 1'b1;
                    end else if (cfg_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        in_bw_d     = cfg_in_bw;
                        wt_bw_d     = cfg_wt_bw;
                        in_signed_d = cfg_in_signed;
                        wt_signed_d = cfg_wt_signed;
                        cnt_d       = cfg_len;
                        state_d     = RUN;
                    end
                end
            end
            RUN: begin
                if (push) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (beat_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // No pushes here, so the FIFO is empty after this edge when the
                // last entry is being popped now.
                if (fifo_empty || (pop && fifo_level == LvlW'(1))) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, latched configuration and pulse registers.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_bw_q     <= '0;
            wt_bw_q     <= '0;
            in_signed_q <= 1'b0;
            wt_signed_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_bw_q     <= in_bw_d;
            wt_bw_q     <= wt_bw_d;
            in_signed_q <= in_signed_d;
            wt_signed_q <= wt_signed_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef FUSION_FMT_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles the consumer back-pressures a valid word.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_accept) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && stall_cnt_q != 16'hffff) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_fusion_operand_formatter.sv
// Directed self-checking bench for fusion_operand_formatter.
module tb_fusion_operand_formatter;

    logic        clk = 1'b0;
    logic        RST;
    logic        cfg_start;
    logic [7:0]  cfg_len;
    logic [2:0]  cfg_in_bw, cfg_wt_bw;
    logic        cfg_in_signed, cfg_wt_signed;
    logic        in_valid, in_ready;
    logic [7:0]  in_act, in_wgt;
    logic        out_valid, out_ready;
    logic [31:0] input_forward, weight;
    logic [2:0]  input_bitwidth, weight_bitwidth;
    logic [3:0]  input_sign, weight_sign;
    logic        out_last, busy, done, err;
`ifdef FUSION_FMT_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] B2 = 3'b001;
    localparam logic [2:0] B4 = 3'b010;
    localparam logic [2:0] B8 = 3'b100;

    fusion_operand_formatter #(
        .DEPTH (2),
        .LEN_W (8)
    ) dut (
        .clk             (clk),
        .RST             (RST),
        .cfg_start       (cfg_start),
        .cfg_len         (cfg_len),
        .cfg_in_bw       (cfg_in_bw),
        .cfg_wt_bw       (cfg_wt_bw),
        .cfg_in_signed   (cfg_in_signed),
        .cfg_wt_signed   (cfg_wt_signed),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_act          (in_act),
        .in_wgt          (in_wgt),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .input_forward   (input_forward),
        .weight          (weight),
        .input_bitwidth  (input_bitwidth),
        .weight_bitwidth (weight_bitwidth),
        .input_sign      (input_sign),
        .weight_sign     (weight_sign),
        .out_last        (out_last),
        .busy            (busy),
`ifdef FUSION_FMT_STATS_EN
        .stall_cnt       (stall_cnt),
`endif
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required to have finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_vec(input logic [7:0] len, input logic [2:0] ibw, input logic [2:0] wbw,
                             input logic isg, input logic wsg);
        cfg_len       = len;
        cfg_in_bw     = ibw;
        cfg_wt_bw     = wbw;
        cfg_in_signed = isg;
        cfg_wt_signed = wsg;
        cfg_start     = 1'b1;
        tick();
        cfg_start     = 1'b0;
    endtask

    task automatic send_one(input logic [7:0] act, input logic [7:0] wgt, output logic ok);
        in_valid = 1'b1;
        in_act   = act;
        in_wgt   = wgt;
        ok       = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Length-1 vector: check the encoded word, then the done pulse after the pop.
    task automatic run_single(input string tag, input logic [2:0] ibw, input logic [2:0] wbw,
                              input logic isg, input logic wsg, input logic [7:0] act,
                              input logic [7:0] wgt, input logic [31:0] exp_if,
                              input logic [31:0] exp_w);
        logic ok;
        out_ready = 1'b0;
        start_vec(8'd1, ibw, wbw, isg, wsg);
        send_one(act, wgt, ok);
        check_eq({tag, "_accept"}, 64'(ok), 64'd1);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_if"}, 64'(input_forward), 64'(exp_if));
        check_eq({tag, "_w"}, 64'(weight), 64'(exp_w));
        check_eq({tag, "_bw"}, 64'({input_bitwidth, weight_bitwidth}), 64'({ibw, wbw}));
        check_eq({tag, "_sign"}, 64'({input_sign, weight_sign}), 64'({{4{isg}}, {4{wsg}}}));
        check_eq({tag, "_last"}, 64'(out_last), 64'd1);
        check_eq({tag, "_rdy_drain"}, 64'({in_ready, busy}), 64'b01);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_done"}, 64'({done, out_valid, busy}), 64'b100);
        tick();
        check_eq({tag, "_done_off"}, 64'(done), 64'd0);
    endtask

    logic [31:0] exp_if4 [4];
    logic [31:0] exp_w4  [4];

    initial begin
        logic ok, acc;
        int   beat, nwords, ndone;

        exp_if4 = '{32'h0000_0055, 32'h0000_00aa, 32'h0000_00ff, 32'h0000_5500};
        exp_w4  = '{32'h1010_1010, 32'h1111_1111, 32'h1212_1212, 32'h1313_1313};

        RST = 1'b1; cfg_start = 1'b0; cfg_len = '0; cfg_in_bw = '0; cfg_wt_bw = '0;
        cfg_in_signed = 1'b0; cfg_wt_signed = 1'b0; in_valid = 1'b0; in_act = '0;
        in_wgt = '0; out_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_ctl", 64'({out_valid, in_ready, busy, done, err, out_last}), 64'd0);
        check_eq("rst_data", {input_forward, weight}, 64'd0);
        check_eq("rst_cfg", 64'({input_bitwidth, weight_bitwidth, input_sign, weight_sign}),
                 64'd0);
        RST = 1'b0;
        tick();

        run_single("u8_a3", B8, B8, 1'b0, 1'b0, 8'd3, 8'd7, 32'h0000_00ff, 32'h0707_0707);
        run_single("u8_a13", B8, B8, 1'b0, 1'b0, 8'd13, 8'd10, 32'h0000_ff55, 32'h0a0a_0a0a);
        run_single("s8_a80", B8, B8, 1'b1, 1'b0, 8'h80, 8'd10, 32'haa00_0000, 32'h0a0a_0a0a);
        run_single("u4_f6", B4, B4, 1'b0, 1'b0, 8'hf6, 8'h9c, 32'h0000_55aa, 32'h0c0c_0c0c);
        run_single("u2_ff", B2, B2, 1'b0, 1'b1, 8'hff, 8'hfe, 32'h0000_00ff, 32'h0202_0202);

        // Back-pressure: only DEPTH beats fit while the consumer stalls.
        out_ready = 1'b0;
        start_vec(8'd4, B8, B8, 1'b0, 1'b0);
        beat = 0;
        in_valid = 1'b1; in_act = 8'd1; in_wgt = 8'h10;
        for (int c = 0; c < 6; c++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                beat++;
                if (beat < 4) begin
                    in_act = 8'(beat + 1);
                    in_wgt = 8'(8'h10 + beat);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check_eq("bp_beats", 64'(beat), 64'd2);
        check_eq("bp_ready", 64'({in_ready, out_valid}), 64'b01);
        check_eq("bp_head", 64'(input_forward), 64'h55);

        out_ready = 1'b1;
        nwords = 0;
        ndone  = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid && out_ready) begin
                if (nwords < 4) begin
                    check_eq($sformatf("bp_if%0d", nwords), 64'(input_forward),
                             64'(exp_if4[nwords]));
                    check_eq($sformatf("bp_w%0d", nwords), 64'(weight), 64'(exp_w4[nwords]));
                    check_eq($sformatf("bp_last%0d", nwords), 64'(out_last),
                             64'(nwords == 3));
                end
                nwords++;
            end
            if (done) ndone++;
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                beat++;
                if (beat < 4) begin
                    in_act = 8'(beat + 1);
                    in_wgt = 8'(8'h10 + beat);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        check_eq("bp_words", 64'(nwords), 64'd4);
        check_eq("bp_done_cnt", 64'(ndone), 64'd1);
        check_eq("bp_idle", 64'(busy), 64'd0);

        // Zero-length vector and illegal config.
        start_vec(8'd0, B8, B8, 1'b0, 1'b0);
        check_eq("len0_done", 64'({done, out_valid, busy, err}), 64'b1000);
        tick();
        check_eq("len0_off", 64'({done, out_valid}), 64'b00);
        start_vec(8'd3, 3'b011, B4, 1'b1, 1'b1);
        check_eq("ill_err", 64'({err, busy, done}), 64'b100);
        check_eq("ill_nolatch", 64'({input_bitwidth, input_sign}), 64'({B8, 4'h0}));
        tick();
        check_eq("ill_off", 64'({err, busy}), 64'b00);

        // Reset mid-vector.
        start_vec(8'd4, B8, B8, 1'b0, 1'b0);
        send_one(8'd1, 8'd2, ok);
        send_one(8'd3, 8'd4, ok);
        check_eq("mid_pre", 64'({busy, out_valid}), 64'b11);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_eq("mid_rst", 64'({out_valid, busy, in_ready, done, err}), 64'd0);
        tick();
        check_eq("mid_nopulse", 64'({done, err, busy}), 64'd0);
        run_single("post_rst", B8, B8, 1'b0, 1'b0, 8'd13, 8'd10, 32'h0000_ff55, 32'h0a0a_0a0a);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
